// File: rtl/ysyx_23060203_rf_wb_ctrl_pkg.sv
// rtl/ysyx_23060203_rf_wb_ctrl_pkg.sv - shared register-file geometry and helpers for the writeback controller
package ysyx_23060203_rf_wb_ctrl_pkg;

    localparam int REG_AW   = 5;
    localparam int NREG     = 32;
    localparam int XLEN_DEF = 32;

    function automatic logic is_x0(input logic [REG_AW-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/ysyx_23060203_rr_arb.sv
// rtl/ysyx_23060203_rr_arb.sv - NREQ-wide round-robin arbiter, one-hot grant, pointer register
module ysyx_23060203_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // Scan from the pointer; the grant is suppressed in reset so nothing is accepted then.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!rst && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt    = PW'((idx + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ysyx_23060203_rf_wb_ctrl.sv
// rtl/ysyx_23060203_rf_wb_ctrl.sv - RF writeback arbiter, busy scoreboard, hazard logic (optional YSYX_23060203_WB_FWD_EN forwarding)
module ysyx_23060203_rf_wb_ctrl
    import ysyx_23060203_rf_wb_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = XLEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_rd,
    output logic                   iss_ready,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    output logic                   rs1_hz,
    output logic                   rs2_hz,
`ifdef YSYX_23060203_WB_FWD_EN
    output logic                   rs1_fwd,
    output logic                   rs2_fwd,
    output logic [XLEN-1:0]        fwd_data,
`endif
    input  logic [NREQ-1:0]        wb_valid,
    output logic [NREQ-1:0]        wb_ready,
    input  logic [NREQ*5-1:0]      wb_rd,
    input  logic [NREQ*XLEN-1:0]   wb_data,
    output logic                   rf_wen,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata
);

    logic [NREQ-1:0]   grant;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              iss_fire;

    ysyx_23060203_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (wb_valid),
        .grant (grant)
    );

    assign wb_ready = grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = wb_rd[i*REG_AW +: REG_AW];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

`ifdef YSYX_23060203_WB_FWD_EN
    logic commit_hit_iss;
    assign commit_hit_iss = rf_wen && (rf_waddr == iss_rd);
    assign iss_ready      = !busy[iss_rd] || commit_hit_iss;
    assign rs1_fwd        = rf_wen && (rf_waddr == rs1_addr) && !is_x0(rs1_addr);
    assign rs2_fwd        = rf_wen && (rf_waddr == rs2_addr) && !is_x0(rs2_addr);
    assign rs1_hz         = busy[rs1_addr] && !rs1_fwd;
    assign rs2_hz         = busy[rs2_addr] && !rs2_fwd;
    assign fwd_data       = rf_wdata;
`else
    assign iss_ready = !busy[iss_rd];
    assign rs1_hz    = busy[rs1_addr];
    assign rs2_hz    = busy[rs2_addr];
`endif

    assign iss_fire = iss_valid && iss_ready;

    // Commit clears first so that an issue to the same rd in the same cycle leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (iss_fire && !is_x0(iss_rd)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            busy   <= busy_nxt;
            rf_wen <= (|grant) && !is_x0(sel_rd);
            if (|grant) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_rf_wb_ctrl.sv
// tb/tb_ysyx_23060203_rf_wb_ctrl.sv - directed self-checking bench for the RF writeback controller
module tb_ysyx_23060203_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hz;
    logic        rs2_hz;
`ifdef YSYX_23060203_WB_FWD_EN
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] fwd_data;
`endif
    logic [1:0]  wb_valid;
    logic [1:0]  wb_ready;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060203_rf_wb_ctrl #(.NREQ(2), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_hz    (rs1_hz),
        .rs2_hz    (rs2_hz),
`ifdef YSYX_23060203_WB_FWD_EN
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd),
        .fwd_data  (fwd_data),
`endif
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        wb_valid  = 2'b11;
        wb_rd     = {5'd2, 5'd1};
        wb_data   = {32'h2222_2222, 32'h1111_1111};

        // Reset held two cycles with both requesters valid
        step();
        step();
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);

        rst      = 1'b0;
        wb_valid = 2'b00;
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        iss_rd   = 5'd5;
        settle();
        chk("rst_rs1_hz", 32'(rs1_hz), 32'd0);
        chk("rst_rs2_hz", 32'(rs2_hz), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        step();
        chk("rst_rf_wen_after", 32'(rf_wen), 32'd0);

        // Issue rd=5, observe hazard, commit from requester 0
        iss_valid = 1'b1;
        iss_rd    = 5'd5;
        settle();
        chk("iss5_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        rs1_addr  = 5'd5;
        settle();
        chk("rs1_hz_5", 32'(rs1_hz), 32'd1);
        chk("iss5_blocked", 32'(iss_ready), 32'd0);

        wb_valid = 2'b01;
        wb_rd    = {5'd0, 5'd5};
        wb_data  = {32'h0, 32'hDEAD_BEEF};
        settle();
        chk("wb5_ready", 32'(wb_ready), 32'b01);
        step();
        wb_valid = 2'b00;
        settle();
        chk("wb5_wen", 32'(rf_wen), 32'd1);
        chk("wb5_waddr", 32'(rf_waddr), 32'd5);
        chk("wb5_wdata", rf_wdata, 32'hDEAD_BEEF);
`ifdef YSYX_23060203_WB_FWD_EN
        chk("wb5_commit_hz", 32'(rs1_hz), 32'd0);
        chk("wb5_fwd", 32'(rs1_fwd), 32'd1);
        chk("wb5_fwd_data", fwd_data, 32'hDEAD_BEEF);
`else
        chk("wb5_commit_hz", 32'(rs1_hz), 32'd1);
`endif
        step();
        chk("wb5_wen_off", 32'(rf_wen), 32'd0);
        chk("rs1_hz_5_clear", 32'(rs1_hz), 32'd0);
        chk("iss5_free", 32'(iss_ready), 32'd1);

        // Requester 1 writes rd=0: accepted, no RF write; pointer back to 0
        wb_valid = 2'b10;
        wb_rd    = {5'd0, 5'd0};
        wb_data  = {32'h0000_1234, 32'h0};
        settle();
        chk("x0_wb_ready", 32'(wb_ready), 32'b10);
        step();
        wb_valid = 2'b00;
        settle();
        chk("x0_no_wen", 32'(rf_wen), 32'd0);

        // Both valid four cycles: alternate grants, one commit per cycle
        wb_valid = 2'b11;
        wb_rd    = {5'd11, 5'd10};
        wb_data  = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        settle();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant_%0d", k), 32'(wb_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            step();
            chk($sformatf("rr_wen_%0d", k), 32'(rf_wen), 32'd1);
            chk($sformatf("rr_waddr_%0d", k), 32'(rf_waddr), (k % 2 == 0) ? 32'd10 : 32'd11);
            chk($sformatf("rr_wdata_%0d", k), rf_wdata, (k % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
        end
        wb_valid = 2'b00;

        // Issue rd=0: always ready, never marked busy
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        settle();
        chk("iss0_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        rs1_addr  = 5'd0;
        settle();
        chk("rs1_hz_x0", 32'(rs1_hz), 32'd0);
        chk("iss0_ready_after", 32'(iss_ready), 32'd1);

        // Issue rd=3, then commit rd=3 while issuing rd=7
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        step();
        iss_valid = 1'b0;
        wb_valid  = 2'b01;
        wb_rd     = {5'd0, 5'd3};
        wb_data   = {32'h0, 32'h3333_3333};
        settle();
        chk("wb3_ready", 32'(wb_ready), 32'b01);
        step();
        wb_valid  = 2'b00;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        settle();
        chk("wb3_wen", 32'(rf_wen), 32'd1);
        chk("iss7_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        rs1_addr  = 5'd7;
        rs2_addr  = 5'd3;
        settle();
        chk("busy7_set", 32'(rs1_hz), 32'd1);
        chk("busy3_clear", 32'(rs2_hz), 32'd0);

        // Reset while rd=9 is outstanding and requester 1 is offering it
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        step();
        iss_valid = 1'b0;
        wb_valid  = 2'b10;
        wb_rd     = {5'd9, 5'd0};
        wb_data   = {32'h9999_9999, 32'h0};
        rst       = 1'b1;
        settle();
        chk("rst_mid_ready", 32'(wb_ready), 32'b00);
        step();
        rst      = 1'b0;
        rs1_addr = 5'd9;
        rs2_addr = 5'd7;
        wb_valid = 2'b11;
        wb_rd    = {5'd9, 5'd4};
        wb_data  = {32'h9999_9999, 32'h4444_4444};
        settle();
        chk("rst_mid_wen", 32'(rf_wen), 32'd0);
        chk("rst_mid_busy9", 32'(rs1_hz), 32'd0);
        chk("rst_mid_busy7", 32'(rs2_hz), 32'd0);
        chk("rst_mid_grant", 32'(wb_ready), 32'b01);
        step();
        wb_valid = 2'b00;
        settle();
        chk("rst_mid_commit_addr", 32'(rf_waddr), 32'd4);
        chk("rst_mid_commit_data", rf_wdata, 32'h4444_4444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
